// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one external fp32 multiplier among NUM_REQ clients.
// One operation in flight: accept, hold operands MUL_LAT cycles, capture, respond.
module fp_mul_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int MUL_LAT = 1,
  parameter int ID_W    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [31:0]             mul_in1,
  output logic [31:0]             mul_in2,
  input  logic [31:0]             mul_final,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    rsp_nan,
  output logic                    rsp_inf,
  output logic                    rsp_zero,
  output logic                    busy,
  output logic [15:0]             ops_done
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d, id_q, id_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       in1_q, in1_d, in2_q, in2_d, data_q, data_d;
  logic              nan_q, nan_d, inf_q, inf_d, zero_q, zero_d;
  logic              vld_q, vld_d, busy_q, busy_d;
  logic [15:0]       ops_q, ops_d;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [31:0]       sel_a, sel_b;
  int                scan;

  // Rotating priority: the scan starts just past the last granted index.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = int'(last_q) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (!gnt_found && state_q == IDLE && req_valid[ID_W'(scan)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(scan);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        req_ready[i] = gnt_found;
        sel_a        = req_a[32*i +: 32];
        sel_b        = req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    data_d  = data_q;
    nan_d   = nan_q;
    inf_d   = inf_q;
    zero_d  = zero_q;
    ops_d   = ops_q;
    case (state_q)
      IDLE: if (gnt_found) begin
        in1_d   = sel_a;
        in2_d   = sel_b;
        id_d    = gnt_idx;
        last_d  = gnt_idx;
        cnt_d   = 4'(MUL_LAT);
        state_d = CALC;
      end
      CALC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          data_d  = mul_final;
          nan_d   = (&mul_final[30:23]) && (|mul_final[22:0]);
          inf_d   = (&mul_final[30:23]) && !(|mul_final[22:0]);
          zero_d  = (mul_final[30:0] == 31'd0);
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready) begin
        ops_d   = ops_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    vld_d  = (state_d == RESP);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      cnt_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      data_q  <= '0;
      nan_q   <= 1'b0;
      inf_q   <= 1'b0;
      zero_q  <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      data_q  <= data_d;
      nan_q   <= nan_d;
      inf_q   <= inf_d;
      zero_q  <= zero_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      ops_q   <= ops_d;
    end
  end

  assign mul_in1   = in1_q;
  assign mul_in2   = in2_q;
  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_nan   = nan_q;
  assign rsp_inf   = inf_q;
  assign rsp_zero  = zero_q;
  assign busy      = busy_q;
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: instance A (2 req, latency 1) runs directed + random
// traffic against a transaction-level model; instance B (3 req, latency 3) checks capture timing.
module tb_fp_mul_arbiter;
  localparam int NA = 2, LA = 1, NB = 3, LB = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // instance A
  logic [NA-1:0] a_req_valid = '0, a_req_ready;
  logic [31:0]   a_opa [NA], a_opb [NA];
  logic [63:0]   a_req_a, a_req_b;
  logic [31:0]   a_in1, a_in2, a_mf, a_rsp_data;
  logic          a_rsp_valid, a_rsp_ready = 1'b0, a_nan, a_inf, a_zero, a_busy;
  logic [0:0]    a_rsp_id;
  logic [15:0]   a_ops;
  // instance B
  logic [NB-1:0] b_req_valid = '0, b_req_ready;
  logic [31:0]   b_opa [NB], b_opb [NB];
  logic [95:0]   b_req_a, b_req_b;
  logic [31:0]   b_in1, b_in2, b_mf, b_mf_man = '0, b_rsp_data;
  logic          b_rsp_valid, b_rsp_ready = 1'b0, b_nan, b_inf, b_zero, b_busy, b_auto = 1'b0;
  logic [1:0]    b_rsp_id;
  logic [15:0]   b_ops;

  assign a_req_a = {a_opa[1], a_opa[0]};
  assign a_req_b = {a_opb[1], a_opb[0]};
  assign b_req_a = {b_opa[2], b_opa[1], b_opa[0]};
  assign b_req_b = {b_opb[2], b_opb[1], b_opb[0]};

  fp_mul_arbiter #(.NUM_REQ(NA), .MUL_LAT(LA), .ID_W(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_a(a_req_a), .req_b(a_req_b), .mul_in1(a_in1), .mul_in2(a_in2), .mul_final(a_mf),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_id(a_rsp_id), .rsp_data(a_rsp_data),
    .rsp_nan(a_nan), .rsp_inf(a_inf), .rsp_zero(a_zero), .busy(a_busy), .ops_done(a_ops));

  fp_mul_arbiter #(.NUM_REQ(NB), .MUL_LAT(LB), .ID_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_a(b_req_a), .req_b(b_req_b), .mul_in1(b_in1), .mul_in2(b_in2), .mul_final(b_mf),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data),
    .rsp_nan(b_nan), .rsp_inf(b_inf), .rsp_zero(b_zero), .busy(b_busy), .ops_done(b_ops));

  // fp32 multiplier stand-in: double-precision product, truncated, FTZ.
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] b;
    b = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'h0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    int e;
    b = $realtobits(r);
    e = int'(b[62:52]) - 896;
    if (b[62:52] == 11'd0 || e <= 0) return {b[63], 31'h0};
    if (e >= 255) return {b[63], 8'hFF, 23'h0};
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    bit nx, ny, ix, iy, zx, zy, s;
    nx = x[30:23] == 8'hFF && x[22:0] != 0;  ny = y[30:23] == 8'hFF && y[22:0] != 0;
    ix = x[30:23] == 8'hFF && x[22:0] == 0;  iy = y[30:23] == 8'hFF && y[22:0] == 0;
    zx = x[30:23] == 8'h00;                  zy = y[30:23] == 8'h00;
    s  = x[31] ^ y[31];
    if (nx || ny || (ix && zy) || (zx && iy)) return 32'h7FC00000;
    if (ix || iy) return {s, 8'hFF, 23'h0};
    if (zx || zy) return {s, 31'h0};
    return r2f(f2r(x) * f2r(y));
  endfunction

  always_comb a_mf = fmul(a_in1, a_in2);
  always_comb b_mf = b_auto ? fmul(b_in1, b_in2) : b_mf_man;

  function automatic int rr_pick(input logic [7:0] v, input int last, input int n);
    int idx;
    for (int k = 1; k <= n; k++) begin
      idx = (last + k) % n;
      if (v[idx[2:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 11))
      0: return 32'h3F800000;
      1: return 32'h40000000;
      2: return 32'hC0000000;
      3: return 32'h7F800000;
      4: return 32'hFFFFFFFF;
      5: return 32'h00000000;
      6: return 32'h80000000;
      7: return 32'h7F000000;
      8: return 32'h00800000;
      default: return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired waiting for DUT event", nm);
  endtask

  // Transaction-level model of A: one op in flight, response valid LA edges after accept.
  bit          m_busy;
  int          m_cyc, m_acc, m_id, m_last;
  logic [31:0] m_a, m_b;
  logic [15:0] m_ops;

  always @(posedge clk or negedge rst_n) begin : mdl_a
    int g;
    if (!rst_n) begin
      m_busy = 0; m_last = NA - 1; m_a = '0; m_b = '0; m_ops = '0; m_cyc = 0; m_id = 0; m_acc = 0;
    end else begin
      g = rr_pick(8'(a_req_valid), m_last, NA);
      if (!m_busy) begin
        if (g >= 0) begin
          m_busy = 1; m_acc = m_cyc + 1; m_id = g; m_last = g;
          m_a = a_opa[g[0]]; m_b = a_opb[g[0]];
        end
      end else if (m_cyc >= m_acc + LA && a_rsp_ready) begin
        m_busy = 0;
        m_ops  = m_ops + 16'd1;
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin : cmp_a
    int g;
    bit ev;
    logic [31:0] ed;
    if (rst_n) begin
      g  = m_busy ? -1 : rr_pick(8'(a_req_valid), m_last, NA);
      ev = m_busy && (m_cyc >= m_acc + LA);
      chk("a_req_ready", 32'(a_req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      chk("a_rsp_valid", 32'(a_rsp_valid), 32'(ev));
      chk("a_busy", 32'(a_busy), 32'(m_busy));
      chk("a_ops_done", 32'(a_ops), 32'(m_ops));
      chk("a_mul_in1", a_in1, m_a);
      chk("a_mul_in2", a_in2, m_b);
      if (ev) begin
        ed = fmul(m_a, m_b);
        chk("a_rsp_data", a_rsp_data, ed);
        chk("a_rsp_id", 32'(a_rsp_id), 32'(m_id));
        chk("a_rsp_nan", 32'(a_nan), 32'(ed[30:23] == 8'hFF && ed[22:0] != 0));
        chk("a_rsp_inf", 32'(a_inf), 32'(ed[30:23] == 8'hFF && ed[22:0] == 0));
        chk("a_rsp_zero", 32'(a_zero), 32'(ed[30:0] == 0));
      end
    end
  end

  task automatic reset_all();
    @(posedge clk); #1;
    rst_n = 1'b0; a_req_valid = '0; b_req_valid = '0; a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drain_a();
    int t;
    a_req_valid = '0; a_rsp_ready = 1'b1; t = 0;
    while (a_busy && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) timeout("a_drain");
  endtask

  // One operation on A; called and returns at posedge+1.
  task automatic a_op(input int i, input logic [31:0] x, input logic [31:0] y, input int stall,
                      output logic [31:0] d, output int id, output logic [2:0] fl);
    int t;
    a_opa[i[0]] = x; a_opb[i[0]] = y;
    a_req_valid[i[0]] = 1'b1;
    a_rsp_ready = (stall == 0);
    #1; t = 0;
    while (!a_req_ready[i[0]] && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) timeout("a_grant");
    @(posedge clk); #1;
    a_req_valid[i[0]] = 1'b0;
    t = 0;
    while (!a_rsp_valid && t < 40) begin @(posedge clk); #1; t++; end
    if (t >= 40) timeout("a_rsp");
    d = a_rsp_data; id = int'(a_rsp_id); fl = {a_nan, a_inf, a_zero};
    if (stall > 0) begin
      a_req_valid = '1;
      repeat (stall) begin
        @(posedge clk); #1;
        chk("bp_data", a_rsp_data, d);
        chk("bp_id", 32'(a_rsp_id), 32'(id));
        chk("bp_req_ready", 32'(a_req_ready), 32'd0);
        chk("bp_busy", 32'(a_busy), 32'd1);
        chk("bp_valid", 32'(a_rsp_valid), 32'd1);
      end
      a_req_valid = '0;
    end
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d, ds [4];
    logic [2:0]  fl;
    logic [15:0] prev;
    int id, got, cyc, ids [4];
    for (int k = 0; k < NA; k++) begin a_opa[k] = '0; a_opb[k] = '0; end
    for (int k = 0; k < NB; k++) begin b_opa[k] = '0; b_opb[k] = '0; end

    // reset state
    #2;
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_ops", 32'(a_ops), 32'd0);
    chk("rst_in1", a_in1, 32'd0);
    chk("rst_data", a_rsp_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // single op
    a_op(0, 32'h3F800000, 32'h40000000, 0, d, id, fl);
    chk("t1_data", d, 32'h40000000);
    chk("t1_id", 32'(id), 32'd0);
    chk("t1_flags", 32'(fl), 32'd0);
    chk("t1_ops", 32'(a_ops), 32'd1);

    // contention
    reset_all();
    a_opa[0] = 32'hC0000000; a_opb[0] = 32'h40000000;
    a_opa[1] = 32'h40400000; a_opb[1] = 32'h40400000;
    a_req_valid = 2'b11; a_rsp_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < 4 && cyc < 60) begin
      @(negedge clk); cyc++;
      chk("t2_onehot", 32'($countones(a_req_ready) <= 1), 32'd1);
      if (a_rsp_valid && a_rsp_ready) begin
        ids[got] = int'(a_rsp_id); ds[got] = a_rsp_data; got++;
      end
    end
    if (got < 4) timeout("t2_responses");
    @(posedge clk); #1;
    a_req_valid = '0;
    for (int k = 0; k < got; k++) begin
      chk("t2_id", 32'(ids[k]), 32'(k % 2));
      chk("t2_data", ds[k], (k % 2) ? 32'h41100000 : 32'hC0800000);
    end
    drain_a();

    // backpressure
    prev = a_ops;
    a_op(0, 32'h40000000, 32'h40000000, 5, d, id, fl);
    chk("t3_data", d, 32'h40800000);
    chk("t3_ops", 32'(a_ops), 32'(16'(prev + 16'd1)));
    @(posedge clk); #1;
    chk("t3_ops_once", 32'(a_ops), 32'(16'(prev + 16'd1)));
    chk("t3_valid_low", 32'(a_rsp_valid), 32'd0);

    // special values
    a_op(1, 32'h7F800000, 32'h3F800000, 0, d, id, fl);
    chk("t4_inf", 32'(fl), 32'b010);
    a_op(0, 32'hFFFFFFFF, 32'h3F800000, 0, d, id, fl);
    chk("t4_nan", 32'(fl), 32'b100);
    a_op(1, 32'h3F800000, 32'h00000000, 0, d, id, fl);
    chk("t4_zero", 32'(fl), 32'b001);
    chk("t4_zero_data", d, 32'h00000000);

    // reset mid-op
    a_opa[0] = 32'h3F800000; a_opb[0] = 32'h40000000;
    a_req_valid = 2'b01; a_rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("t6_busy", 32'(a_busy), 32'd1);
    rst_n = 1'b0; a_req_valid = '0;
    #1;
    chk("t6_rst_busy", 32'(a_busy), 32'd0);
    chk("t6_rst_valid", 32'(a_rsp_valid), 32'd0);
    chk("t6_rst_in1", a_in1, 32'd0);
    chk("t6_rst_in2", a_in2, 32'd0);
    chk("t6_rst_ops", 32'(a_ops), 32'd0);
    chk("t6_rst_id", 32'(a_rsp_id), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    a_op(1, 32'h40400000, 32'h40000000, 0, d, id, fl);
    chk("t6_id", 32'(id), 32'd1);
    chk("t6_data", d, 32'h40C00000);
    reset_all();
    a_req_valid = 2'b11; #1;
    chk("t6_prio", 32'(a_req_ready), 32'b01);
    @(posedge clk); #1;
    drain_a();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      a_req_valid = 2'($urandom);
      for (int k = 0; k < NA; k++) begin a_opa[k] = rnd_op(); a_opb[k] = rnd_op(); end
      a_rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drain_a();

    // B: latency 3, mul_final only sampled at E0+3
    @(posedge clk); #1;
    b_opa[1] = 32'h40000000; b_opb[1] = 32'h40400000;
    b_req_valid = 3'b010; b_mf_man = 32'hDEAD0000;
    @(negedge clk);
    chk("t5_grant", 32'(b_req_ready), 32'b010);
    @(posedge clk); #1;
    b_req_valid = '0; b_mf_man = 32'h7F800000;
    chk("t5_v0", 32'(b_rsp_valid), 32'd0);
    chk("t5_in1", b_in1, 32'h40000000);
    @(posedge clk); #1;
    b_mf_man = 32'h12345678;
    chk("t5_v1", 32'(b_rsp_valid), 32'd0);
    @(posedge clk); #1;
    b_mf_man = 32'h40C00000;
    chk("t5_v2", 32'(b_rsp_valid), 32'd0);
    chk("t5_hold", b_in2, 32'h40400000);
    @(posedge clk); #1;
    b_mf_man = 32'hFFFFFFFF;
    chk("t5_v3", 32'(b_rsp_valid), 32'd1);
    chk("t5_data", b_rsp_data, 32'h40C00000);
    chk("t5_id", 32'(b_rsp_id), 32'd1);
    chk("t5_flags", 32'({b_nan, b_inf, b_zero}), 32'd0);
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_done", 32'(b_rsp_valid), 32'd0);
    chk("t5_ops", 32'(b_ops), 32'd1);

    // B round-robin wraps over three requesters
    b_auto = 1'b1;
    b_opa[0] = 32'h3F800000; b_opb[0] = 32'h40000000;
    b_opa[1] = 32'h40400000; b_opb[1] = 32'h40400000;
    b_opa[2] = 32'h40000000; b_opb[2] = 32'hC0000000;
    b_req_valid = 3'b111;
    got = 0; cyc = 0;
    while (got < 3 && cyc < 80) begin
      @(negedge clk); cyc++;
      chk("b_onehot", 32'($countones(b_req_ready) <= 1), 32'd1);
      if (b_rsp_valid && b_rsp_ready) begin
        ids[got] = int'(b_rsp_id); ds[got] = b_rsp_data; got++;
      end
    end
    if (got < 3) timeout("b_responses");
    @(posedge clk); #1;
    b_req_valid = '0;
    if (got == 3) begin
      chk("b_id0", 32'(ids[0]), 32'd2); chk("b_d0", ds[0], 32'hC0800000);
      chk("b_id1", 32'(ids[1]), 32'd0); chk("b_d1", ds[1], 32'h40000000);
      chk("b_id2", 32'(ids[2]), 32'd1); chk("b_d2", ds[2], 32'h41100000);
    end
    cyc = 0;
    while (b_busy && cyc < 50) begin @(posedge clk); #1; cyc++; end
    if (cyc >= 50) timeout("b_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
